// File: rtl/s2p_sync_ctrl_if.sv
// Serial receive bus: bit-serial input, byte-parallel output and lock status.
interface s2p_sync_ctrl_if;
    logic       data_in;
    logic [7:0] data_out;
    logic       valid_out;
    logic       active;
    logic [1:0] state_out;

    modport master (
        output data_in,
        input  data_out,
        input  valid_out,
        input  active,
        input  state_out
    );

    modport slave (
        input  data_in,
        output data_out,
        output valid_out,
        output active,
        output state_out
    );
endinterface

// File: rtl/s2p_sync_ctrl.sv
// Comma-based byte alignment and lock controller for the serial receive path.
// Shifts MSB first on clk_32f, locks after LOCK_COUNT aligned commas.
module s2p_sync_ctrl #(
    parameter logic [7:0] COMMA      = 8'hBC,
    parameter int         LOCK_COUNT = 4,
    parameter int         MAX_GAP    = 16
) (
    input  logic                 clk_32f,
    input  logic                 reset,
    s2p_sync_ctrl_if.slave       bus
);

    typedef enum logic [1:0] {
        SEARCH = 2'd0,
        ALIGN  = 2'd1,
        LOCKED = 2'd2
    } state_t;

    localparam logic [3:0] LOCK_N = 4'(LOCK_COUNT);
    localparam logic [7:0] GAP_N  = 8'(MAX_GAP);

    state_t     state_q, state_d;
    logic [7:0] sr_q, sr_d;
    logic [2:0] bit_cnt_q, bit_cnt_d;
    logic [3:0] bc_cnt_q, bc_cnt_d;
    logic [7:0] gap_cnt_q, gap_cnt_d;
    logic [7:0] data_q, data_d;
    logic       valid_q, valid_d;
    logic       active_q, active_d;

    logic [7:0] cand;
    logic       is_comma;
    logic       boundary;
    logic [3:0] bc_inc;
    logic [7:0] gap_inc;

    always_comb begin
        cand     = {sr_q[6:0], bus.data_in};
        is_comma = (cand == COMMA);
        boundary = (bit_cnt_q == 3'd7);
        bc_inc   = (bc_cnt_q == 4'hF) ? 4'hF : bc_cnt_q + 4'd1;
        gap_inc  = gap_cnt_q + 8'd1;

        state_d   = state_q;
        sr_d      = cand;
        bit_cnt_d = (state_q == SEARCH) ? bit_cnt_q : bit_cnt_q + 3'd1;
        bc_cnt_d  = bc_cnt_q;
        gap_cnt_d = gap_cnt_q;
        data_d    = data_q;
        valid_d   = 1'b0;
        active_d  = active_q;

        unique case (state_q)
            SEARCH: begin
                active_d = 1'b0;
                if (is_comma) begin
                    bit_cnt_d = 3'd0;
                    bc_cnt_d  = 4'd1;
                    if (LOCK_N == 4'd1) begin
                        state_d   = LOCKED;
                        active_d  = 1'b1;
                        gap_cnt_d = 8'd0;
                    end else begin
                        state_d = ALIGN;
                    end
                end
            end
            ALIGN: begin
                if (boundary) begin
                    if (is_comma) begin
                        bc_cnt_d = bc_inc;
                        if (bc_inc == LOCK_N) begin
                            state_d   = LOCKED;
                            active_d  = 1'b1;
                            gap_cnt_d = 8'd0;
                        end
                    end else begin
                        state_d  = SEARCH;
                        bc_cnt_d = 4'd0;
                    end
                end
            end
            LOCKED: begin
                if (boundary) begin
                    if (is_comma) begin
                        gap_cnt_d = 8'd0;
                    end else begin
                        data_d    = cand;
                        valid_d   = 1'b1;
                        gap_cnt_d = gap_inc;
                        // The byte that exhausts the gap budget is still delivered.
                        if (gap_inc == GAP_N) begin
                            state_d  = SEARCH;
                            active_d = 1'b0;
                            bc_cnt_d = 4'd0;
                        end
                    end
                end
            end
            default: begin
                state_d  = SEARCH;
                active_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk_32f) begin
        if (reset) begin
            state_q   <= SEARCH;
            sr_q      <= 8'd0;
            bit_cnt_q <= 3'd0;
            bc_cnt_q  <= 4'd0;
            gap_cnt_q <= 8'd0;
            data_q    <= 8'd0;
            valid_q   <= 1'b0;
            active_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            sr_q      <= sr_d;
            bit_cnt_q <= bit_cnt_d;
            bc_cnt_q  <= bc_cnt_d;
            gap_cnt_q <= gap_cnt_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
            active_q  <= active_d;
        end
    end

    assign bus.data_out  = data_q;
    assign bus.valid_out = valid_q;
    assign bus.active    = active_q;
    assign bus.state_out = state_q;

endmodule
